pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Generic, parametrised LC-3b pipeline stage register. Replaces the fixed per-stage load-enabled register banks (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle with a valid/ready handshake.
- A 1-entry skid buffer lets in_ready be driven from a register, so no combinational ready path crosses the stage.
- Synchronous flush inserts a bubble: control cleared to zero, so no writeback or memory access occurs downstream.

Parameters:
- CTRL_W, 8, width of the control bundle; all-zero encodes a NOP/bubble.
- DATA_W, 64, width of the data bundle (PC, operands, IR fields, register indices).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries; highest priority.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept; register output, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  main register holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bundle; zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle; contents don't-care when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready (optional feature).
- squash_cnt  out  CNT_W  valid entries discarded by flush (optional feature).

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register {m_valid, m_ctrl, m_data} and skid register {s_valid, s_ctrl, s_data}.
- Outputs: out_valid=m_valid, out_ctrl=m_ctrl, out_data=m_data, in_ready=!s_valid.
- Reset (async, any time, including mid-transfer):
  - m_valid=s_valid=0, m_ctrl=s_ctrl=0, m_data=s_data=0, counters=0.
  - Therefore out_valid=0 and in_ready=1 immediately.
- States: EMPTY (m=0,s=0), FULL (m=1,s=0), SKID (m=1,s=1). The state m=0,s=1 is illegal and unreachable.
- EMPTY:
  - in_fire -> FULL, main <= input.
  - Otherwise stay in EMPTY.
- FULL:
  - in_fire & out_fire -> FULL, main <= input.
  - in_fire & !out_fire -> SKID, skid <= input, main holds.
  - !in_fire & out_fire -> EMPTY, m_ctrl <= 0.
  - Neither -> hold.
- SKID:
  - in_ready=0, so no in_fire is possible.
  - out_fire -> FULL, main <= skid, s_valid <= 0, s_ctrl <= 0.
  - Otherwise hold.
- Flush (synchronous, overrides every transition above):
  - Next state EMPTY; m_valid, s_valid, m_ctrl, s_ctrl <= 0.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed downstream.
- Latency and throughput:
  - Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
  - Sustained throughput is 1 entry/cycle while out_ready=1.
- Stall behaviour:
  - out_valid, out_ctrl, out_data hold stable while out_valid & !out_ready.
  - At most 2 entries are held.
- Ordering: entries leave in arrival order; no duplication, no loss except by flush or reset.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - squash_cnt increments by 1 per cycle where flush=1 and (m_valid | s_valid).
  - Both counters saturate at 2^CNT_W-1 and clear only on reset.
- Not defined: counter logic is absent; stall_cnt and squash_cnt are driven constant 0. Port list is unchanged.

Test Plan:
- Streaming: out_ready=1, in_valid=1, in_ctrl=1..5 on consecutive cycles -> out_ctrl=1..5 one cycle later each, in_ready constantly 1.
- Skid fill: hold out_ready=0, present A then B -> after 2 edges SKID, in_ready=0, out_ctrl=A. Then raise out_ready -> A, B delivered on consecutive cycles, in_ready returns to 1 after the first out_fire.
- Flush in SKID: flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, new input not captured. With PIPE_STAGE_PERF_EN, squash_cnt=1.
- Async reset while FULL, asserted mid-cycle -> out_valid=0 and out_ctrl=0 before the next edge; after deassert, the first accepted entry appears with 1-cycle latency.
- Stall counter: with PIPE_STAGE_PERF_EN and CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage (ctrl + data bundles) with a 1-entry skid; flush squashes to a zero-ctrl bubble.
// Latency 1 cycle, 1 entry/cycle sustained; in_ready comes straight from a flop (state bit 1).
// Backpressure: holds up to 2 entries; PIPE_STAGE_PERF_EN adds saturating stall/squash counters.
module pipe_stage_elastic #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  // Encoding chosen so bit0 is the main valid and bit1 is the skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [DATA_W-1:0]   r_m_data;
  logic [CTRL_W-1:0]   r_s_ctrl;
  logic [DATA_W-1:0]   r_s_data;

  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;
  logic w_clr_main;
  logic w_clr_skid;

  assign in_ready   = ~r_state[1];
  assign out_valid  = r_state[0];
  assign out_ctrl   = r_m_ctrl;
  assign out_data   = r_m_data;
  assign w_in_fire  = in_valid & ~r_state[1];
  assign w_out_fire = r_state[0] & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_main     = 1'b0;
    w_clr_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt  = ST_FULL;
          w_ld_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_SKID;
          w_ld_skid   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
          w_clr_main  = 1'b1;
        end
      end
      ST_SKID: begin
        if (w_out_fire) begin
          w_state_nxt    = ST_FULL;
          w_ld_main_skid = 1'b1;
          w_clr_skid     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_clr_main  = 1'b1;
        w_clr_skid  = 1'b1;
      end
    endcase
    // Flush wins over everything, including a same-cycle accept.
    if (flush) begin
      w_state_nxt    = ST_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      w_clr_main     = 1'b1;
      w_clr_skid     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_EMPTY;
      r_m_ctrl <= '0;
      r_m_data <= '0;
      r_s_ctrl <= '0;
      r_s_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_main_in) begin
        r_m_ctrl <= in_ctrl;
        r_m_data <= in_data;
      end else if (w_ld_main_skid) begin
        r_m_ctrl <= r_s_ctrl;
        r_m_data <= r_s_data;
      end else if (w_clr_main) begin
        r_m_ctrl <= '0;
      end
      if (w_ld_skid) begin
        r_s_ctrl <= in_ctrl;
        r_s_data <= in_data;
      end else if (w_clr_skid) begin
        r_s_ctrl <= '0;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_squash_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (r_state[0] && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush && (r_state != ST_EMPTY) && (r_squash_cnt != '1)) begin
        r_squash_cnt <= r_squash_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign squash_cnt = r_squash_cnt;
`else
  assign stall_cnt  = '0;
  assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: stimulus queues expected entries, a negedge monitor pops on out_fire.
module tb_pipe_stage_elastic;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  squash_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [CTRL_W+DATA_W-1:0] exp_q[$];
  logic [CTRL_W+DATA_W-1:0] mon_exp;

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // One input cycle: drive after the edge, decide acceptance at the following negedge.
  task automatic cyc(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    in_valid = v; in_ctrl = c; in_data = d;
    @(negedge clk);
    if (v) begin
      chk("accept", in_ready, 1);
      if (in_ready) exp_q.push_back({c, d});
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got ctrl %0h, want no output", out_ctrl);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("sb_ctrl", out_ctrl, mon_exp[DATA_W +: CTRL_W]);
          chk("sb_data", out_data, mon_exp[DATA_W-1:0]);
        end
      end
      if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_squash", squash_cnt, 0);
    @(negedge clk); reset = 1'b0;

    // Streaming at full rate, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, CTRL_W'(i), 64'hDEAD_0000_0000_0000 | 64'(i));
      if (i > 1) chk("stream_lat", out_ctrl, 64'(i - 1));
    end
    cyc(1'b0, '0, '0);
    chk("stream_last", out_ctrl, 5);
    drain();

    // Skid fill with downstream stalled.
    out_ready = 1'b0;
    cyc(1'b1, 8'hA1, 64'h0000_AAAA_0000_0001);
    cyc(1'b1, 8'hB2, 64'h0000_BBBB_0000_0002);
    cyc(1'b0, '0, '0);
    chk("skid_in_ready", in_ready, 0);
    chk("skid_out_valid", out_valid, 1);
    chk("skid_out_ctrl", out_ctrl, 8'hA1);
    cyc(1'b0, '0, '0);
    chk("skid_hold_ctrl", out_ctrl, 8'hA1);
    chk("skid_hold_data", out_data, 64'h0000_AAAA_0000_0001);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("unskid_in_ready", in_ready, 1);
    chk("unskid_out_ctrl", out_ctrl, 8'hB2);
    drain();
    chk("skid_done_valid", out_valid, 0);

    // Flush while in SKID with a pending input.
    out_ready = 1'b0;
    cyc(1'b1, 8'hC3, 64'h3);
    cyc(1'b1, 8'hD4, 64'h4);
    cyc(1'b0, '0, '0);
    chk("pre_flush_rdy", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'hE5; in_data = 64'h5;
    @(posedge clk);
    exp_q.delete();
    #1; flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_squash1", squash_cnt, PERF ? 1 : 0);

    // Flush in FULL discards a same-cycle accept.
    cyc(1'b1, 8'hF6, 64'h6);
    @(posedge clk); #1;
    chk("full_ctrl", out_ctrl, 8'hF6);
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'h77; in_data = 64'h7;
    @(negedge clk);
    chk("flush_full_rdy", in_ready, 1);
    @(posedge clk);
    exp_q.delete();
    #1; flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", out_valid, 0);
    chk("flush_squash2", squash_cnt, PERF ? 2 : 0);
    @(negedge clk);
    chk("flush2_no_capture", out_valid, 0);

    // Async reset asserted mid-cycle while FULL.
    cyc(1'b1, 8'h88, 64'h8);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("pre_rst_ctrl", out_ctrl, 8'h88);
    @(negedge clk); #2; reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_squash", squash_cnt, 0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk); #2; reset = 1'b0;
    cyc(1'b1, 8'h99, 64'h9);
    cyc(1'b0, '0, '0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_ctrl", out_ctrl, 8'h99);
    drain();
    chk("post_rst_stall", stall_cnt, 0);

    // Stall counter saturation.
    out_ready = 1'b0;
    cyc(1'b1, 8'hAA, 64'hA);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0);
    chk("stall_sat", stall_cnt, PERF ? 15 : 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_ctrl", out_ctrl, 8'hAA);
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
